// File: rtl/scan_addr_gen_if.sv
// Bus between the scan address generator and its consumer.
//   start/mode[/serp]  : frame request (sampled by the generator in IDLE)
//   ready              : consumer accepts the current address
//   addr/addr_valid    : current pixel address and its qualifier
//   line_last          : addr is the final element of its line
//   frame_last         : addr is the final element of the frame
//   done/busy          : completion pulse and activity flag
// Serpentine traversal adds the serp request bit when SCAN_SERPENTINE_EN is defined.
interface scan_addr_gen_if #(parameter int ADDR_W = 15) ();
  logic              start;
  logic [1:0]        mode;
`ifdef SCAN_SERPENTINE_EN
  logic              serp;
`endif
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              line_last;
  logic              frame_last;
  logic              done;
  logic              busy;

  // master: address generator side
  modport master (
    input  start, input mode,
`ifdef SCAN_SERPENTINE_EN
    input  serp,
`endif
    input  ready,
    output addr, output addr_valid, output line_last, output frame_last,
    output done, output busy
  );

  // slave: consumer side
  modport slave (
    output start, output mode,
`ifdef SCAN_SERPENTINE_EN
    output serp,
`endif
    output ready,
    input  addr, input addr_valid, input line_last, input frame_last,
    input  done, input busy
  );
endinterface

// File: rtl/scan_addr_gen.sv
// Image-scan address generator for a ROWS x COLS frame.
// Traversal orders: 0 row-major, 1 column-major, 2 anti-diagonals (r+c const),
// 3 diagonals (c-r const). One address per accepted handshake, no bubbles.
// Ports:
//   clk      : clock, rising edge
//   resetIn  : asynchronous active-low reset
//   enb      : enable; low forces IDLE on the next edge (no done pulse)
//   bus      : scan_addr_gen_if.master (start/mode/ready in, addr + markers out)
// Optional: SCAN_SERPENTINE_EN adds bus.serp; odd lines of modes 0/1 run reversed.
// addr = row*COLS + col is built from an incrementally maintained row base,
// so no multiplier is needed. Diagonal modes keep the line-start position
// (ls_*) to step to the next line's first element.
module scan_addr_gen #(
  parameter int COLS   = 150,
  parameter int ROWS   = 150,
  parameter int ADDR_W = 15,
  parameter int IDX_W  = 8
) (
  input  logic            clk,
  input  logic            resetIn,
  input  logic            enb,
  scan_addr_gen_if.master bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0]  COL_MAX   = IDX_W'(COLS-1);
  localparam logic [IDX_W-1:0]  ROW_MAX   = IDX_W'(ROWS-1);
  localparam logic [IDX_W-1:0]  ONE_I     = IDX_W'(1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((ROWS-1)*COLS);

  state_t            state, state_n;
  logic [1:0]        mode_q, mode_n;
  logic              serp_q, serp_n;
  logic [IDX_W-1:0]  row, row_n, col, col_n, ls_row, ls_row_n, ls_col, ls_col_n;
  logic [ADDR_W-1:0] base, base_n, ls_base, ls_base_n;
  logic              valid, hs, ll, fl, rev, nrev;

  assign valid = (state == SCAN);
  assign hs    = valid & bus.ready;

  // Line/frame markers for the current element; rev = current line reversed.
  always_comb begin
    rev = 1'b0;
    ll  = 1'b0;
    fl  = 1'b0;
    case (mode_q)
      2'd0: begin
        rev = serp_q & row[0];
        ll  = rev ? (col == '0) : (col == COL_MAX);
        fl  = ll && (row == ROW_MAX);
      end
      2'd1: begin
        rev = serp_q & col[0];
        ll  = rev ? (row == '0) : (row == ROW_MAX);
        fl  = ll && (col == COL_MAX);
      end
      2'd2: begin
        ll = (row == ROW_MAX) || (col == '0);
        fl = (row == ROW_MAX) && (col == COL_MAX);
      end
      default: begin
        ll = (row == ROW_MAX) || (col == COL_MAX);
        fl = (row == '0) && (col == COL_MAX);
      end
    endcase
    nrev = serp_q & ~rev;
  end

  always_comb begin
    state_n   = state;
    mode_n    = mode_q;
    serp_n    = serp_q;
    row_n     = row;
    col_n     = col;
    base_n    = base;
    ls_row_n  = ls_row;
    ls_col_n  = ls_col;
    ls_base_n = ls_base;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = SCAN;
          mode_n  = bus.mode;
`ifdef SCAN_SERPENTINE_EN
          serp_n  = bus.serp;
`else
          serp_n  = 1'b0;
`endif
          // Diagonal order starts at the bottom-left corner.
          if (bus.mode == 2'd3) begin
            row_n     = ROW_MAX;
            base_n    = LAST_BASE;
            ls_row_n  = ROW_MAX;
            ls_base_n = LAST_BASE;
          end
        end
      end
      SCAN: begin
        if (hs) begin
          if (fl) begin
            state_n   = DONE;
            row_n     = '0;
            col_n     = '0;
            base_n    = '0;
            ls_row_n  = '0;
            ls_col_n  = '0;
            ls_base_n = '0;
          end else begin
            case (mode_q)
              2'd0: begin
                if (ll) begin
                  row_n  = row + ONE_I;
                  base_n = base + COLS_A;
                  col_n  = nrev ? COL_MAX : '0;
                end else begin
                  col_n  = rev ? col - ONE_I : col + ONE_I;
                end
              end
              2'd1: begin
                if (ll) begin
                  col_n  = col + ONE_I;
                  row_n  = nrev ? ROW_MAX : '0;
                  base_n = nrev ? LAST_BASE : '0;
                end else begin
                  row_n  = rev ? row - ONE_I : row + ONE_I;
                  base_n = rev ? base - COLS_A : base + COLS_A;
                end
              end
              2'd2: begin
                if (ll) begin
                  // Start slides right along row 0, then down the last column.
                  if (ls_col != COL_MAX) begin
                    ls_col_n  = ls_col + ONE_I;
                  end else begin
                    ls_row_n  = ls_row + ONE_I;
                    ls_base_n = ls_base + COLS_A;
                  end
                  row_n  = ls_row_n;
                  col_n  = ls_col_n;
                  base_n = ls_base_n;
                end else begin
                  row_n  = row + ONE_I;
                  col_n  = col - ONE_I;
                  base_n = base + COLS_A;
                end
              end
              default: begin
                if (ll) begin
                  // Start climbs column 0, then slides right along row 0.
                  if (ls_row != '0) begin
                    ls_row_n  = ls_row - ONE_I;
                    ls_base_n = ls_base - COLS_A;
                  end else begin
                    ls_col_n  = ls_col + ONE_I;
                  end
                  row_n  = ls_row_n;
                  col_n  = ls_col_n;
                  base_n = ls_base_n;
                end else begin
                  row_n  = row + ONE_I;
                  col_n  = col + ONE_I;
                  base_n = base + COLS_A;
                end
              end
            endcase
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Enable low wins over start and ready.
    if (!enb) begin
      state_n   = IDLE;
      mode_n    = '0;
      serp_n    = 1'b0;
      row_n     = '0;
      col_n     = '0;
      base_n    = '0;
      ls_row_n  = '0;
      ls_col_n  = '0;
      ls_base_n = '0;
    end
  end

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      state   <= IDLE;
      mode_q  <= '0;
      serp_q  <= 1'b0;
      row     <= '0;
      col     <= '0;
      base    <= '0;
      ls_row  <= '0;
      ls_col  <= '0;
      ls_base <= '0;
    end else begin
      state   <= state_n;
      mode_q  <= mode_n;
      serp_q  <= serp_n;
      row     <= row_n;
      col     <= col_n;
      base    <= base_n;
      ls_row  <= ls_row_n;
      ls_col  <= ls_col_n;
      ls_base <= ls_base_n;
    end
  end

  assign bus.addr       = valid ? base + ADDR_W'(col) : '0;
  assign bus.addr_valid = valid;
  assign bus.line_last  = valid & ll;
  assign bus.frame_last = valid & fl;
  assign bus.done       = (state == DONE);
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_scan_addr_gen.sv
// Scoreboard bench for scan_addr_gen on a 3x4 frame: expected address
// streams come from a brute-force line enumeration and are popped on each
// accepted handshake.
module tb_scan_addr_gen;
  localparam int COLS = 4, ROWS = 3, ADDR_W = 4, IDX_W = 3;

  logic clk = 1'b0, resetIn = 1'b0, enb = 1'b0;
  always #5 clk = ~clk;

  scan_addr_gen_if #(.ADDR_W(ADDR_W)) bus ();
  scan_addr_gen #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .IDX_W(IDX_W))
    dut (.clk(clk), .resetIn(resetIn), .enb(enb), .bus(bus));

  typedef struct {int a; bit ll; bit fl;} exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic void push(input int a, input bit ll, input bit fl);
    exp_t e;
    e.a = a; e.ll = ll; e.fl = fl;
    exp_q.push_back(e);
  endfunction

  task automatic build(input int m, input bit s);
    exp_q.delete();
    case (m)
      0: for (int r = 0; r < ROWS; r++)
           for (int j = 0; j < COLS; j++)
             push(r*COLS + ((s && r%2 == 1) ? COLS-1-j : j), j == COLS-1,
                  r == ROWS-1 && j == COLS-1);
      1: for (int c = 0; c < COLS; c++)
           for (int j = 0; j < ROWS; j++)
             push(((s && c%2 == 1) ? ROWS-1-j : j)*COLS + c, j == ROWS-1,
                  c == COLS-1 && j == ROWS-1);
      2: for (int k = 0; k <= ROWS+COLS-2; k++) begin
           int rlo, rhi;
           rlo = (k-COLS+1 > 0) ? k-COLS+1 : 0;
           rhi = (k < ROWS-1) ? k : ROWS-1;
           for (int r = rlo; r <= rhi; r++)
             push(r*COLS + k - r, r == rhi, k == ROWS+COLS-2 && r == rhi);
         end
      default: for (int d = -(ROWS-1); d <= COLS-1; d++) begin
           int rlo, rhi;
           rlo = (d < 0) ? -d : 0;
           rhi = (ROWS-1 < COLS-1-d) ? ROWS-1 : COLS-1-d;
           for (int r = rlo; r <= rhi; r++)
             push(r*COLS + r + d, r == rhi, d == COLS-1 && r == rhi);
         end
    endcase
  endtask

  // rdy_mode: 0 = ready held high, 1 = repeating 1,0,0,1, 2 = random
  task automatic run_scan(input int m, input int rdy_mode, input bit s);
    exp_t e;
    int cyc, prev_a;
    bit stalled;
    build(m, s);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'(m); bus.ready = 1'b1;
`ifdef SCAN_SERPENTINE_EN
    bus.serp = s;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode = 2'(m) ^ 2'b01;  // must be ignored mid-scan
    chk("first_valid", int'(bus.addr_valid), 1);
    cyc = 0; stalled = 1'b0; prev_a = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      if (stalled) chk("stall_hold", int'(bus.addr), prev_a);
      case (rdy_mode)
        0:       bus.ready = 1'b1;
        1:       bus.ready = (cyc%4 == 0) || (cyc%4 == 3);
        default: bus.ready = 1'($urandom_range(0, 1));
      endcase
      chk("valid_mid", int'(bus.addr_valid), 1);
      chk("busy_mid", int'(bus.busy), 1);
      stalled = bus.addr_valid && !bus.ready;
      prev_a = int'(bus.addr);
      if (bus.addr_valid && bus.ready) begin
        e = exp_q.pop_front();
        chk($sformatf("addr m%0d", m), int'(bus.addr), e.a);
        chk($sformatf("line_last m%0d a%0d", m, e.a), int'(bus.line_last), int'(e.ll));
        chk($sformatf("frame_last m%0d a%0d", m, e.a), int'(bus.frame_last), int'(e.fl));
      end
      cyc++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) chk("timeout_left", exp_q.size(), 0);
    if (rdy_mode == 0) chk("no_bubble_cycles", cyc, ROWS*COLS);
    chk("done_pulse", int'(bus.done), 1);
    chk("busy_done", int'(bus.busy), 1);
    chk("valid_done", int'(bus.addr_valid), 0);
    @(negedge clk);
    chk("done_clear", int'(bus.done), 0);
    chk("busy_idle", int'(bus.busy), 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 2'd0; bus.ready = 1'b0;
`ifdef SCAN_SERPENTINE_EN
    bus.serp = 1'b0;
`endif
    #1;
    chk("rst_addr", int'(bus.addr), 0);
    chk("rst_valid", int'(bus.addr_valid), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ll", int'(bus.line_last), 0);
    chk("rst_fl", int'(bus.frame_last), 0);
    @(negedge clk);
    resetIn = 1'b1; enb = 1'b1;

    run_scan(0, 0, 1'b0);
    run_scan(1, 0, 1'b0);
    run_scan(2, 0, 1'b0);
    run_scan(3, 0, 1'b0);
    run_scan(0, 1, 1'b0);
    run_scan(2, 2, 1'b0);
    run_scan(3, 2, 1'b0);

    // Enable drop at addr 6
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd0; bus.ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      chk("pre_abort_addr", int'(bus.addr), i);
      if (i < 6) @(negedge clk);
    end
    enb = 1'b0;
    @(negedge clk);
    chk("abort_valid", int'(bus.addr_valid), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_addr", int'(bus.addr), 0);
    @(negedge clk);
    chk("abort_no_done", int'(bus.done), 0);
    enb = 1'b1;
    run_scan(0, 0, 1'b0);

    // Asynchronous reset mid-scan
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd1; bus.ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 resetIn = 1'b0;
    #1;
    chk("async_rst_valid", int'(bus.addr_valid), 0);
    chk("async_rst_addr", int'(bus.addr), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_ll", int'(bus.line_last), 0);
    @(negedge clk);
    resetIn = 1'b1;
    run_scan(3, 0, 1'b0);

`ifdef SCAN_SERPENTINE_EN
    run_scan(0, 0, 1'b1);
    run_scan(1, 0, 1'b1);
    run_scan(2, 0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
